// File: rtl/dac_write_scheduler.sv
// Two-channel DAC write scheduler: per-channel holding registers, a tick-latched
// frame set, and a serializer handshake with an acknowledge timeout.
module dac_write_scheduler #(
    parameter int ACK_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sample_tick,
    input  logic        ch0_valid,
    input  logic        ch1_valid,
    input  logic [11:0] ch0_data,
    input  logic [11:0] ch1_data,
    output logic        ch0_ready,
    output logic        ch1_ready,
    output logic [15:0] spi_word,
    output logic        spi_start,
    input  logic        spi_busy,
    output logic [7:0]  overrun_cnt,
    output logic        ack_err
);
    localparam int TW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE} state_t;

    state_t           state_q;
    logic [1:0]       full_q, full_d;
    logic [1:0]       frame_q;
    logic [1:0][11:0] data_q;
    logic [1:0]       vld;
    logic [1:0][11:0] din;
    logic             armed_q;
    logic             sel_q;
    logic [TW-1:0]    tmr_q;
    logic [15:0]      word_q;
    logic             start_q;
    logic [7:0]       ovr_q;
    logic             err_q;
    logic             issue_go;

    assign vld       = {ch1_valid, ch0_valid};
    assign din       = {ch1_data, ch0_data};
    assign ch0_ready = ~full_q[0];
    assign ch1_ready = ~full_q[1];
    assign spi_word    = word_q;
    assign spi_start   = start_q;
    assign overrun_cnt = ovr_q;
    assign ack_err     = err_q;

    // ISSUE spends one cycle selecting the channel (armed_q), then fires once the serializer is idle
    assign issue_go = (state_q == ISSUE) && armed_q && !spi_busy;

    always_comb begin
        full_d = full_q;
        if (issue_go) full_d[sel_q] = 1'b0;
        for (int i = 0; i < 2; i++)
            if (vld[i] && !full_q[i]) full_d[i] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q <= '0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            for (int i = 0; i < 2; i++)
                if (vld[i] && !full_q[i]) data_q[i] <= din[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            frame_q <= '0;
            armed_q <= 1'b0;
            sel_q   <= 1'b0;
            tmr_q   <= '0;
            word_q  <= '0;
            start_q <= 1'b0;
            ovr_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            start_q <= 1'b0;
            if (sample_tick && state_q != IDLE && ovr_q != 8'hFF) ovr_q <= ovr_q + 8'd1;
            case (state_q)
                IDLE: if (sample_tick && |full_q) begin
                    frame_q <= full_q;
                    armed_q <= 1'b0;
                    state_q <= ISSUE;
                end
                ISSUE: if (!armed_q) begin
                    sel_q   <= ~frame_q[0];
                    armed_q <= 1'b1;
                end else if (!spi_busy) begin
                    word_q         <= {sel_q, 1'b0, 1'b1, 1'b1, data_q[sel_q]};
                    start_q        <= 1'b1;
                    frame_q[sel_q] <= 1'b0;
                    armed_q        <= 1'b0;
                    tmr_q          <= '0;
                    state_q        <= WAIT_ACK;
                end
                WAIT_ACK: if (spi_busy) begin
                    state_q <= WAIT_DONE;
                end else if (tmr_q == TW'(ACK_TIMEOUT - 1)) begin
                    err_q   <= 1'b1;
                    state_q <= WAIT_DONE;
                end else begin
                    tmr_q <= tmr_q + 1'b1;
                end
                WAIT_DONE: if (!spi_busy) state_q <= (|frame_q) ? ISSUE : IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dac_write_scheduler.sv
// Directed bench for dac_write_scheduler with a small serializer model that
// acknowledges each start with a programmable busy window.
module tb_dac_write_scheduler;
    logic        clk = 0, rst = 1, sample_tick = 0;
    logic        ch0_valid = 0, ch1_valid = 0;
    logic [11:0] ch0_data = 0, ch1_data = 0;
    logic        ch0_ready, ch1_ready, spi_start, spi_busy, ack_err;
    logic [15:0] spi_word;
    logic [7:0]  overrun_cnt;

    int total = 0, bad = 0;
    int nstarts = 0;
    logic [15:0] last_word = 0;
    int busy_len = 16;
    logic ack_en = 1;
    int bcnt = 0;

    dac_write_scheduler #(.ACK_TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .sample_tick(sample_tick),
        .ch0_valid(ch0_valid), .ch1_valid(ch1_valid),
        .ch0_data(ch0_data), .ch1_data(ch1_data),
        .ch0_ready(ch0_ready), .ch1_ready(ch1_ready),
        .spi_word(spi_word), .spi_start(spi_start), .spi_busy(spi_busy),
        .overrun_cnt(overrun_cnt), .ack_err(ack_err)
    );

    always #5 clk = ~clk;

    // serializer model and start logger
    always @(posedge clk) begin
        if (spi_start) begin
            nstarts   <= nstarts + 1;
            last_word <= spi_word;
        end
        if (spi_start && ack_en) bcnt <= busy_len;
        else if (bcnt != 0) bcnt <= bcnt - 1;
    end
    assign spi_busy = (bcnt != 0);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load(input int ch, input logic [11:0] d);
        if (ch == 0) begin ch0_valid = 1; ch0_data = d; end
        else begin ch1_valid = 1; ch1_data = d; end
        @(negedge clk);
        ch0_valid = 0; ch1_valid = 0;
    endtask

    task automatic tick();
        sample_tick = 1;
        @(negedge clk);
        sample_tick = 0;
    endtask

    task automatic wait_starts(input string tag, input int target, input int budget);
        for (int i = 0; i < budget && nstarts < target; i++) @(negedge clk);
        chk(tag, nstarts, target);
    endtask

    initial begin
        cyc(3);
        chk("rst_ready0", ch0_ready, 1);
        chk("rst_ready1", ch1_ready, 1);
        chk("rst_start", spi_start, 0);
        chk("rst_word", spi_word, 16'h0000);
        chk("rst_ovr", overrun_cnt, 0);
        chk("rst_err", ack_err, 0);
        rst = 0;
        cyc(2);

        // two-channel frame with latency check
        ch0_valid = 1; ch0_data = 12'h123; ch1_valid = 1; ch1_data = 12'hABC;
        @(negedge clk);
        ch0_valid = 0; ch1_valid = 0;
        chk("full_ready0", ch0_ready, 0);
        chk("full_ready1", ch1_ready, 0);
        sample_tick = 1;
        @(negedge clk);               // edge N
        sample_tick = 0;
        chk("lat_n", spi_start, 0);
        @(negedge clk);               // edge N+1
        chk("lat_n1", spi_start, 0);
        @(negedge clk);               // edge N+2
        chk("lat_n2", spi_start, 1);
        chk("word_ch0", spi_word, 16'h3123);
        @(negedge clk);
        chk("start_pulse", spi_start, 0);
        chk("ready0_after", ch0_ready, 1);
        load(0, 12'h555);             // reload mid-frame: not part of this frame
        wait_starts("frame_two", 2, 60);
        chk("word_ch1", last_word, 16'hBABC);
        cyc(40);
        chk("frame_only2", nstarts, 2);
        chk("word_stable", spi_word, 16'hBABC);
        chk("ready1_end", ch1_ready, 1);
        chk("reload_held", ch0_ready, 0);
        tick();
        wait_starts("reload_start", 3, 60);
        chk("reload_word", last_word, 16'h3555);
        cyc(30);

        // ch1 only
        load(1, 12'h7FF);
        tick();
        wait_starts("ch1_only", 4, 60);
        chk("ch1_word", last_word, 16'hB7FF);
        cyc(40);
        chk("ch1_single", nstarts, 4);

        // full register is not overwritten
        ch0_valid = 1; ch0_data = 12'h111;
        @(negedge clk);
        ch0_data = 12'h222;
        cyc(4);
        chk("hold_ready", ch0_ready, 0);
        ch0_valid = 0;
        tick();
        wait_starts("hold_start", 5, 60);
        chk("hold_word", last_word, 16'h3111);
        cyc(40);

        // overrun: three ticks while a frame is active
        load(0, 12'h010);
        tick();
        cyc(3); tick(); cyc(2); tick(); cyc(2); tick();
        wait_starts("ovr_start", 6, 60);
        cyc(40);
        chk("ovr3", overrun_cnt, 3);
        busy_len = 400;
        load(0, 12'h020);
        sample_tick = 1;
        cyc(301);
        sample_tick = 0;
        chk("ovr_sat", overrun_cnt, 255);
        cyc(450);
        busy_len = 16;

        // acknowledge timeout
        ack_en = 0;
        load(0, 12'h0AA);
        tick();
        wait_starts("to_start", 8, 60);
        cyc(10);
        chk("to_early", ack_err, 0);
        cyc(10);
        chk("to_set", ack_err, 1);
        ack_en = 1;
        cyc(5);
        load(1, 12'h001);
        tick();
        wait_starts("to_recover", 9, 60);
        chk("to_rec_word", last_word, 16'hB001);
        cyc(40);

        // reset mid-frame with ch1 still pending
        load(0, 12'h321);
        load(1, 12'h654);
        tick();
        wait_starts("rf_start", 10, 60);
        chk("rf_word", last_word, 16'h3321);
        cyc(5);
        rst = 1;
        @(negedge clk);
        chk("rf_ready0", ch0_ready, 1);
        chk("rf_ready1", ch1_ready, 1);
        chk("rf_word0", spi_word, 16'h0000);
        chk("rf_ovr", overrun_cnt, 0);
        chk("rf_err", ack_err, 0);
        rst = 0;
        cyc(40);
        chk("rf_nostart", nstarts, 10);
        tick();
        cyc(10);
        chk("rf_empty_tick", nstarts, 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dac_write_scheduler.md
DAC_WRITE_SCHEDULER -- requirements
Module: dac_write_scheduler

Interface
REQ-001 SHALL have parameter ACK_TIMEOUT, default 15, max cycles to wait for spi_busy to rise after a start pulse.
REQ-002 SHALL have port clk, input, 1, system clock; all logic on rising edge.
REQ-003 SHALL have port rst, input, 1, reset, synchronous, active-high.
REQ-004 SHALL have port sample_tick, input, 1, one-cycle DDS sample-rate strobe.
REQ-005 SHALL have ports ch0_valid/ch1_valid, input, 1 each, requester sample valid.
REQ-006 SHALL have ports ch0_data/ch1_data, input, 12 each, requester sample value.
REQ-007 SHALL have ports ch0_ready/ch1_ready, output, 1 each, high when that channel's holding register is empty.
REQ-008 SHALL have port spi_word, output, 16, command word to SPI DAC serializer.
REQ-009 SHALL have port spi_start, output, 1, one-cycle transfer request to serializer.
REQ-010 SHALL have port spi_busy, input, 1, serializer transfer in progress.
REQ-011 SHALL have port overrun_cnt, output, 8, saturating count of ticks lost while a frame was active.
REQ-012 SHALL have port ack_err, output, 1, sticky flag: serializer failed to acknowledge a start.

Function
REQ-013 SHALL hold one 12-bit sample per channel; a transfer occurs when chN_valid and chN_ready are both high at a clock edge, loading data and marking the channel full.
REQ-014 SHALL drive chN_ready = not full; a full register SHALL NOT be overwritten.
REQ-015 SHALL use states IDLE, ISSUE, WAIT_ACK, WAIT_DONE.
REQ-016 IDLE: sample_tick high and at least one register full -> ISSUE, latching the full flags as the frame set; tick with none full -> stay IDLE, no counting.
REQ-017 ISSUE: select lowest-index channel in the frame set; when spi_busy low, on the next edge register spi_word and pulse spi_start for exactly one cycle, clear that channel's full flag and frame bit, go WAIT_ACK; spi_busy high -> wait in ISSUE.
REQ-018 spi_word format: bit15 channel index, bit14 0 (unbuffered), bit13 1 (gain 1x), bit12 1 (active), bits11:0 sample.
REQ-019 WAIT_ACK: spi_busy high -> WAIT_DONE; after ACK_TIMEOUT cycles without it, set ack_err and go WAIT_DONE.
REQ-020 WAIT_DONE: spi_busy low -> ISSUE if frame set non-empty, else IDLE.
REQ-021 Latency: tick sampled at edge N in IDLE with serializer idle -> spi_start high in the cycle following edge N+2.
REQ-022 sample_tick high in any state other than IDLE SHALL increment overrun_cnt, saturating at 255, and SHALL NOT start a new frame.
REQ-023 Channels filled after frame-set latch SHALL wait for the next tick.
REQ-024 A channel emptied by issue SHALL show ready high the cycle after spi_start and may reload immediately; the reloaded sample is not in the current frame.
REQ-025 spi_word SHALL remain stable from spi_start until the next spi_start.

Reset
REQ-026 On rst: state IDLE, both registers empty (ready = 1), frame set clear, spi_start 0, spi_word 0x0000, overrun_cnt 0, ack_err 0.
REQ-027 rst mid-frame SHALL discard pending samples and the frame set; no spi_start SHALL follow until a new tick after rst deasserts.

Verification
REQ-028 Load ch0=0x123, ch1=0xABC, tick, serializer busy 16 cycles each -> spi_word 0x3123 then 0xBABC, two start pulses, both ready high afterward.
REQ-029 Only ch1 loaded = 0x7FF, tick -> single start, spi_word 0xB7FF.
REQ-030 Three ticks during an active frame -> overrun_cnt 3; 300 such ticks -> 255.
REQ-031 spi_busy held low after start -> ack_err set after 15 cycles, FSM returns to IDLE/ISSUE without hang.
REQ-032 ch0_valid held with register full -> ch0_ready low, data unchanged until issue.
REQ-033 rst asserted in WAIT_DONE with ch1 pending -> all outputs at reset values, no further start until next post-reset tick.
